// File: rtl/store_capture_pkg.sv
// Shared types and defaults for the store capture endpoint.
package store_capture_pkg;

    // One captured store: the byte address and the data written.
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
    } store_entry_t;

    localparam logic [31:0] DONE_ADR_DEFAULT = 32'h0000_0064;
    localparam logic [31:0] WIN_LO_DEFAULT   = 32'h0000_0000;
    localparam logic [31:0] WIN_HI_DEFAULT   = 32'h0000_00FF;

    // Inclusive, unsigned window test.
    function automatic logic in_window(input logic [31:0] adr,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (adr >= lo) && (adr <= hi);
    endfunction

endpackage

// File: rtl/store_capture_fifo_sync_fifo.sv
// Single-clock FIFO with registered storage and a separately tracked
// occupancy count, so full and empty never depend on pointer comparison.
// The head is read straight from the storage flops, which keeps the
// consumer side free of any combinational path from the push inputs.
module sync_fifo
    import store_capture_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = store_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  entry_t           push_data_i,
    input  logic             pop_i,
    output entry_t           head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full;
    logic               empty;
    logic               pop_ok;
    logic               push_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // is still accepted when the head is leaving.
    always_comb begin
        pop_ok   = pop_i & ~empty;
        push_ok  = push_i & (~full | pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and occupancy; reset clears storage so the head
    // reads as zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full;
    assign empty_o = empty;
    assign count_o = count_q;

endmodule

// File: rtl/store_capture_fifo.sv
// Snoops the core's store bus, buffers stores that fall inside the
// capture window, and flags the program's completion store.
// Modes fall out of the sticky flags: idle while start is low, capturing
// otherwise, with done and overflow raised independently; capture keeps
// running after either flag sets.
module store_capture_fifo
    import store_capture_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] WIN_LO   = WIN_LO_DEFAULT,
    parameter logic [31:0] WIN_HI   = WIN_HI_DEFAULT,
    parameter logic [31:0] DONE_ADR = DONE_ADR_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         MemWrite,
    input  logic [31:0]                  DataAdr,
    input  logic [31:0]                  WriteData,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_adr,
    output logic [31:0]                  out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         done,
    output logic [31:0]                  done_data
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    store_entry_t     push_entry;
    store_entry_t     head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    logic             qualified;
    logic             done_hit;
    logic             pop;
    logic             push;
    logic             drop;

    logic             overflow_q, overflow_d;
    logic             done_q, done_d;
    logic [31:0]      done_data_q, done_data_d;

    // Store qualification and FIFO handshake.
    always_comb begin
        qualified       = start & MemWrite & in_window(DataAdr, WIN_LO, WIN_HI);
        done_hit        = start & MemWrite & (DataAdr == DONE_ADR);
        pop             = ~fifo_empty & out_ready;
        push            = qualified & (~fifo_full | pop);
        drop            = qualified & fifo_full & ~pop;
        push_entry.adr  = DataAdr;
        push_entry.data = WriteData;
    end

    sync_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (store_entry_t)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Sticky flags; only the first completion store latches its data.
    always_comb begin
        overflow_d  = overflow_q | drop;
        done_d      = done_q | done_hit;
        done_data_d = done_data_q;
        if (done_hit && !done_q) begin
            done_data_d = WriteData;
        end
    end

    // Flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
            done_data_q <= '0;
        end else begin
            overflow_q  <= overflow_d;
            done_q      <= done_d;
            done_data_q <= done_data_d;
        end
    end

    assign out_valid = ~fifo_empty;
    assign out_adr   = head.adr;
    assign out_data  = head.data;
    assign count     = fifo_count;
    assign overflow  = overflow_q;
    assign done      = done_q;
    assign done_data = done_data_q;

endmodule

// File: tb/tb_store_capture_fifo.sv
module tb_store_capture_fifo;
    import store_capture_pkg::*;

    localparam int          DEPTH    = 8;
    localparam int          CNT_W    = $clog2(DEPTH + 1);
    localparam logic [31:0] WIN_LO   = 32'h0000_0000;
    localparam logic [31:0] WIN_HI   = 32'h0000_00FF;
    localparam logic [31:0] DONE_ADR = 32'h0000_0064;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             MemWrite;
    logic [31:0]      DataAdr;
    logic [31:0]      WriteData;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_adr;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             done;
    logic [31:0]      done_data;

    int n_tests = 0;
    int n_fail  = 0;

    store_entry_t sb[$];
    logic         exp_ovf;
    logic         exp_done;
    logic [31:0]  exp_done_data;

    store_capture_fifo #(
        .DEPTH    (DEPTH),
        .WIN_LO   (WIN_LO),
        .WIN_HI   (WIN_HI),
        .DONE_ADR (DONE_ADR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_adr   (out_adr),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow),
        .done      (done),
        .done_data (done_data)
    );

    always #5 clk = ~clk;

    function automatic logic tb_in_win(input logic [31:0] a);
        return (a >= WIN_LO) && (a <= WIN_HI);
    endfunction

    // One clock of stimulus; model updated from pre-edge state, popped
    // entries compared against the DUT head before the edge.
    task automatic cycle(input logic st, input logic mw, input logic [31:0] adr,
                         input logic [31:0] dat, input logic rdy);
        int           sz;
        logic         pop;
        logic         qual;
        store_entry_t e;
        @(negedge clk);
        start     = st;
        MemWrite  = mw;
        DataAdr   = adr;
        WriteData = dat;
        out_ready = rdy;
        sz   = sb.size();
        pop  = rdy && (sz > 0);
        qual = st && mw && tb_in_win(adr);
        if (pop) begin
            e = sb.pop_front();
            n_tests++;
            if (out_valid !== 1'b1 || out_adr !== e.adr || out_data !== e.data) begin
                n_fail++;
                $display("FAIL pop_head: got valid=%0b adr=%h data=%h, expected valid=1 adr=%h data=%h",
                         out_valid, out_adr, out_data, e.adr, e.data);
            end
        end
        if (qual) begin
            if (sz < DEPTH || pop) begin
                e.adr  = adr;
                e.data = dat;
                sb.push_back(e);
            end else begin
                exp_ovf = 1'b1;
            end
        end
        if (st && mw && adr == DONE_ADR && !exp_done) begin
            exp_done      = 1'b1;
            exp_done_data = dat;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        @(negedge clk);
        reset     = 1'b1;
        out_ready = rdy;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        exp_ovf       = 1'b0;
        exp_done      = 1'b0;
        exp_done_data = '0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() > 0 && guard < 2 * DEPTH + 4) begin
            cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            guard++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; MemWrite = 0; DataAdr = 0; WriteData = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        do_reset(1'b0);
        n_tests++;
        if (out_valid !== 1'b0 || out_adr !== 32'h0 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_head: got valid=%0b adr=%h data=%h, expected 0 0 0", out_valid, out_adr, out_data);
        end
        n_tests++;
        if (count !== '0 || overflow !== 1'b0 || done !== 1'b0 || done_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_flags: got count=%0d ovf=%0b done=%0b done_data=%h, expected 0 0 0 0",
                     count, overflow, done, done_data);
        end
    endtask

    task automatic test_window();
        cycle(1'b1, 1'b1, 32'h100, 32'd5, 1'b0);
        n_tests++;
        if (count !== '0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL window_out: got count=%0d valid=%0b, expected 0 0", count, out_valid);
        end
        cycle(1'b0, 1'b1, 32'h10, 32'd5, 1'b0);
        cycle(1'b0, 1'b1, DONE_ADR, 32'd6, 1'b0);
        n_tests++;
        if (count !== '0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL start_low: got count=%0d done=%0b, expected 0 0", count, done);
        end
        cycle(1'b1, 1'b1, 32'hFF, 32'd1, 1'b0);
        n_tests++;
        if (count !== CNT_W'(1) || out_valid !== 1'b1 || out_adr !== 32'hFF) begin
            n_fail++;
            $display("FAIL window_hi_edge: got count=%0d valid=%0b adr=%h, expected 1 1 000000ff",
                     count, out_valid, out_adr);
        end
        drain();
    endtask

    task automatic test_basic();
        do_reset(1'b0);
        cycle(1'b1, 1'b1, 32'h60, 32'd3, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || out_adr !== 32'h60 || out_data !== 32'd3 || count !== CNT_W'(1)) begin
            n_fail++;
            $display("FAIL push_latency: got valid=%0b adr=%h data=%h count=%0d, expected 1 60 3 1",
                     out_valid, out_adr, out_data, count);
        end
        cycle(1'b1, 1'b1, DONE_ADR, 32'd7, 1'b0);
        n_tests++;
        if (done !== 1'b1 || done_data !== 32'd7 || count !== CNT_W'(2)) begin
            n_fail++;
            $display("FAIL basic_done: got done=%0b done_data=%0d count=%0d, expected 1 7 2", done, done_data, count);
        end
        n_tests++;
        if (out_adr !== 32'h60 || out_data !== 32'd3) begin
            n_fail++;
            $display("FAIL basic_head_stable: got adr=%h data=%h, expected 60 3", out_adr, out_data);
        end
        drain();
    endtask

    task automatic test_overflow();
        do_reset(1'b0);
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 1'b1, 32'(4 * i), 32'(100 + i), 1'b0);
        end
        n_tests++;
        if (count !== CNT_W'(8) || overflow !== 1'b1 || exp_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow: got count=%0d ovf=%0b, expected 8 1", count, overflow);
        end
        n_tests++;
        if (sb.size() != 8 || sb[7].adr !== 32'h1C) begin
            n_fail++;
            $display("FAIL overflow_model: got %0d entries, expected 8 ending at 1c", sb.size());
        end
        drain();
        n_tests++;
        if (count !== '0 || out_valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_drained: got count=%0d valid=%0b ovf=%0b, expected 0 0 1", count, out_valid, overflow);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b1, 32'(32'h80 + 4 * i), 32'(32'h200 + i), 1'b0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b1, 32'(32'hA0 + 4 * i), 32'(32'h300 + i), 1'b1);
            n_tests++;
            if (count !== CNT_W'(8) || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL full_push_pop[%0d]: got count=%0d ovf=%0b, expected 8 0", i, count, overflow);
            end
        end
        drain();
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        n_tests++;
        if (count !== '0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_when_empty: got count=%0d valid=%0b, expected 0 0", count, out_valid);
        end
    endtask

    task automatic test_repeat_done();
        do_reset(1'b0);
        cycle(1'b1, 1'b1, DONE_ADR, 32'd7, 1'b1);
        cycle(1'b1, 1'b1, DONE_ADR, 32'd9, 1'b1);
        n_tests++;
        if (done !== 1'b1 || done_data !== 32'd7 || done_data !== exp_done_data) begin
            n_fail++;
            $display("FAIL repeat_done: got done=%0b done_data=%0d, expected 1 7", done, done_data);
        end
        drain();
    endtask

    task automatic test_reset_mid_drain();
        do_reset(1'b0);
        cycle(1'b1, 1'b1, 32'h10, 32'd1, 1'b0);
        cycle(1'b1, 1'b1, 32'h14, 32'd2, 1'b0);
        cycle(1'b1, 1'b1, DONE_ADR, 32'd7, 1'b0);
        cycle(1'b1, 1'b1, 32'h18, 32'd3, 1'b0);
        n_tests++;
        if (count !== CNT_W'(4) || done !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_prefill: got count=%0d done=%0b, expected 4 1", count, done);
        end
        do_reset(1'b1);
        n_tests++;
        if (count !== '0 || out_valid !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got count=%0d valid=%0b done=%0b ovf=%0b, expected 0 0 0 0",
                     count, out_valid, done, overflow);
        end
        cycle(1'b1, 1'b1, 32'h20, 32'd5, 1'b0);
        n_tests++;
        if (count !== CNT_W'(1) || out_adr !== 32'h20 || out_data !== 32'd5) begin
            n_fail++;
            $display("FAIL post_reset_push: got count=%0d adr=%h data=%h, expected 1 20 5", count, out_adr, out_data);
        end
        drain();
    endtask

    initial begin
        exp_ovf       = 1'b0;
        exp_done      = 1'b0;
        exp_done_data = '0;
        test_reset();
        test_window();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_repeat_done();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/store_capture_fifo.md
# store_capture_fifo

Receive-side endpoint for the single-cycle ARM core's data-store port. Sits beside the data memory on the `MemWrite`/`DataAdr`/`WriteData` bus and snoops every store that hits a configurable address window. Captured stores go into a small FIFO that a host, bench or debug UART drains over a valid/ready port. Raises a sticky `done` flag, with the stored value, when the program writes its completion address.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries. Must be a power of two, at least 2.
- `WIN_LO`, 32'h0000_0000: inclusive lower bound of the capture window (byte address).
- `WIN_HI`, 32'h0000_00FF: inclusive upper bound of the capture window.
- `DONE_ADR`, 32'h0000_0064: completion address.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high. Clears all state.
- `start` in 1: capture enable. Stores are ignored while low.
- `MemWrite` in 1: core store strobe.
- `DataAdr` in 32: store address.
- `WriteData` in 32: store data.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: consumer accepts the head.
- `out_adr` out 32: head address.
- `out_data` out 32: head data.
- `count` out $clog2(DEPTH+1): current occupancy.
- `overflow` out 1: sticky. A qualified store was dropped.
- `done` out 1: sticky. A store to `DONE_ADR` was seen.
- `done_data` out 32: data of the first store to `DONE_ADR`.

## Operation
- Qualified store: `start & MemWrite & (WIN_LO <= DataAdr <= WIN_HI)`, sampled at the rising edge. All comparisons are unsigned, 32-bit.
- Push: a qualified store pushes `{DataAdr, WriteData}` when `count < DEPTH` or a pop happens in the same cycle.
- Drop: a qualified store with a full FIFO and no pop is dropped. `overflow` sets to 1 and stays set until reset.
- Pop: occurs when `out_valid & out_ready`. `out_ready` while empty has no effect.
- Simultaneous push and pop: `count` stays the same. This holds when full (no drop) and when `count` = 1 (the new entry becomes the head on the next cycle).
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap modulo `DEPTH`. `count` is tracked separately, so full and empty are never ambiguous.
- Done detection:
  - Condition is `start & MemWrite & DataAdr == DONE_ADR`, independent of the window and of FIFO space.
  - The first hit sets `done` and latches `done_data`. Later hits do not change `done_data`.
  - The same store is also pushed if it is qualified.
- Operating modes, selected by `done`/`overflow` (no other FSM):
  - IDLE: `start` = 0.
  - CAPTURE.
  - DONE: `done` = 1. Capture continues.
  - OVF: `overflow` = 1. Capture continues.
- `start` deassertion: stops new captures only. Already-buffered entries can still be drained.

## Timing
- Reset values: `out_valid` = 0, `out_adr` = 0, `out_data` = 0, `count` = 0, `overflow` = 0, `done` = 0, `done_data` = 0. Pointers = 0.
- Reset mid-operation: buffered entries are discarded. The next cycle behaves as empty.
- Push latency: a store accepted at edge N shows as `out_valid` = 1 with its head data after edge N when the FIFO was empty. There are no combinational paths from store inputs to outputs.
- `out_adr`/`out_data` are stable while `out_valid & !out_ready`.
- `count`, `overflow`, `done` and `done_data` update at the same edge as the triggering event.
- Throughput: one push and one pop per cycle.

## Structure
- Package `store_capture_pkg`:
  - typedef `store_entry_t` = struct {`logic [31:0] adr`; `logic [31:0] data`;}.
  - localparam `DONE_ADR_DEFAULT` = 32'h64.
- Sub-module `sync_fifo`: parameterised by `DEPTH` and entry type. Provides push/pop/full/empty/count. The top adds window qualification, overflow and done logic.

## Test plan
- Reset, then `start` = 1 and stores to 0x60=3, 0x64=7, with `out_ready` = 0:
  - `count` = 2.
  - `done` = 1 and `done_data` = 7 at the edge of the 0x64 store.
  - Head is {0x60, 3}.
- Window filter: store to 0x100 with data 5 → `count` unchanged, no `out_valid`. Same store with `start` = 0 → ignored.
- Overflow: 9 stores (0x00..0x20, step 4) with `out_ready` = 0 and `DEPTH` = 8:
  - `count` = 8 and `overflow` = 1.
  - Draining returns exactly the first 8 entries, in order.
- Simultaneous push/pop when full, `out_ready` = 1:
  - `count` stays 8 and `overflow` stays 0.
  - Drain order is preserved across pointer wrap-around.
- Repeat done: stores 0x64=7 then 0x64=9 → `done_data` stays 7.
- Reset mid-drain with 4 buffered: next cycle `count` = 0, `out_valid` = 0, `done` = 0, `overflow` = 0.
